// File: rtl/east_link_out.sv
// East output stage: buffers eastbound packets in a small FIFO and sends them
// onto the inter-router link under credit-based flow control.
module east_link_out #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  packet_in,
  input  logic                         valid_in,
  output logic                         in_ready,
  output logic [15:0]                  link_packet,
  output logic                         link_valid,
  input  logic                         credit_in,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [$clog2(CREDITS):0]     credits,
  output logic                         overflow_err,
  output logic                         credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CREDITS) + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [CW-1:0] MAX_CRED = CW'(CREDITS);

  logic [15:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] credits_r;
  logic [15:0]   link_packet_r;
  logic          link_valid_r;
  logic          overflow_err_r;
  logic          credit_err_r;

  logic [PW-1:0] occupancy_s;
  logic          in_ready_s;
  logic          push_s;
  logic          send_s;
  logic [CW-1:0] credits_nxt_s;
  logic          credit_err_set_s;

  // The extra pointer bit makes the difference a true entry count, 0..DEPTH.
  assign occupancy_s = wr_ptr_r - rd_ptr_r;
  assign in_ready_s  = (occupancy_s != FULL_CNT);

  // Push/send decisions and next credit count.
  always_comb begin
    push_s           = 1'b0;
    send_s           = 1'b0;
    credits_nxt_s    = credits_r;
    credit_err_set_s = 1'b0;
    if (valid_in && in_ready_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((occupancy_s != {PW{1'b0}}) && (credits_r != {CW{1'b0}})) begin
      send_s = 1'b1;
    end else begin
      send_s = 1'b0;
    end
    case ({send_s, credit_in})
      2'b10: credits_nxt_s = credits_r - CW'(1);
      2'b01: begin
        if (credits_r == MAX_CRED) begin
          credits_nxt_s    = credits_r;
          credit_err_set_s = 1'b1;
        end else begin
          credits_nxt_s    = credits_r + CW'(1);
        end
      end
      default: credits_nxt_s = credits_r;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r[AW-1:0]] <= packet_in;
    end
  end

  // Pointers, credits, link register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      credits_r      <= MAX_CRED;
      link_packet_r  <= 16'h0000;
      link_valid_r   <= 1'b0;
      overflow_err_r <= 1'b0;
      credit_err_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (send_s) begin
        link_packet_r <= mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r      <= rd_ptr_r + PW'(1);
      end
      link_valid_r <= send_s;
      credits_r    <= credits_nxt_s;
      if (valid_in && !in_ready_s) begin
        overflow_err_r <= 1'b1;
      end
      if (credit_err_set_s) begin
        credit_err_r <= 1'b1;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign occupancy    = occupancy_s;
  assign credits      = credits_r;
  assign link_packet  = link_packet_r;
  assign link_valid   = link_valid_r;
  assign overflow_err = overflow_err_r;
  assign credit_err   = credit_err_r;

endmodule

// File: tb/tb_east_link_out.sv
// Self-checking bench for east_link_out: a cycle model plus a scoreboard queue
// of accepted packets, popped whenever the link presents a flit.
module tb_east_link_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] packet_in;
  logic        valid_in;
  logic        in_ready;
  logic [15:0] link_packet;
  logic        link_valid;
  logic        credit_in;
  logic [2:0]  occupancy;
  logic [2:0]  credits;
  logic        overflow_err;
  logic        credit_err;

  east_link_out #(.DEPTH(4), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .valid_in(valid_in),
    .in_ready(in_ready), .link_packet(link_packet), .link_valid(link_valid),
    .credit_in(credit_in), .occupancy(occupancy), .credits(credits),
    .overflow_err(overflow_err), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  int   m_occ;
  int   m_cred;
  logic m_send;
  logic m_ovf;
  logic m_cerr;
  int   sent_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; credit_in = 1'b0; packet_in = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_occ = 0; m_cred = 4; m_send = 1'b0; m_ovf = 1'b0; m_cerr = 1'b0;
    check_val("rst_occ", occupancy, 32'd0);
    check_val("rst_cred", credits, 32'd4);
    check_val("rst_lv", link_valid, 32'd0);
    check_val("rst_lp", link_packet, 32'h0);
    check_val("rst_ovf", overflow_err, 32'd0);
    check_val("rst_cerr", credit_err, 32'd0);
    check_val("rst_rdy", in_ready, 32'd1);
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic v, input logic [15:0] p, input logic c);
    logic push;
    logic [15:0] want;
    valid_in = v; packet_in = p; credit_in = c;
    #1;
    check_val("in_ready", in_ready, (m_occ != 4) ? 32'd1 : 32'd0);
    m_send = (m_occ != 0) && (m_cred != 0);
    push   = v && (m_occ != 4);
    if (v && !push) m_ovf = 1'b1;
    if (push) exp_q.push_back(p);
    if (m_send && !c) m_cred = m_cred - 1;
    else if (!m_send && c) begin
      if (m_cred == 4) m_cerr = 1'b1;
      else m_cred = m_cred + 1;
    end
    m_occ = m_occ + (push ? 1 : 0) - (m_send ? 1 : 0);
    @(posedge clk); #1;
    check_val("occ", occupancy, m_occ);
    check_val("cred", credits, m_cred);
    check_val("lv", link_valid, m_send);
    check_val("ovf", overflow_err, m_ovf);
    check_val("cerr", credit_err, m_cerr);
    if (link_valid) begin
      sent_cnt++;
      if (exp_q.size() == 0) begin
        check_val("spurious_flit", link_packet, 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check_val("pkt", link_packet, want);
      end
    end
    valid_in = 1'b0; credit_in = 1'b0;
  endtask

  initial begin
    sent_cnt = 0;
    rst = 1'b1; valid_in = 1'b0; credit_in = 1'b0; packet_in = 16'h0000;
    @(posedge clk); #1;
    do_reset();

    // Three back-to-back pushes stream out one per cycle.
    step(1'b1, 16'h1234, 1'b0);
    check_val("t1_cred_a", credits, 32'd4);
    step(1'b1, 16'h5678, 1'b0);
    check_val("t1_cred_b", credits, 32'd3);
    step(1'b1, 16'h9ABC, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check_val("t1_cred_end", credits, 32'd1);
    check_val("t1_occ_end", occupancy, 32'd0);
    step(1'b0, 16'h0000, 1'b0);

    // Exhaust credits, fill the FIFO, overflow, then release one flit per credit.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'hD000 + 16'(i), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check_val("t2_cred0", credits, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'hE000 + 16'(i), 1'b0);
    check_val("t2_full_occ", occupancy, 32'd4);
    check_val("t2_full_rdy", in_ready, 32'd0);
    check_val("t2_ovf", overflow_err, 32'd1);
    sent_cnt = 0;
    step(1'b0, 16'h0000, 1'b1);
    check_val("t2_no_lv_yet", link_valid, 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    check_val("t2_one_lv", link_valid, 32'd1);
    check_val("t2_oldest", link_packet, 32'hE000);
    step(1'b0, 16'h0000, 1'b0);
    check_val("t2_single", sent_cnt, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, (m_cred < 4));
    check_val("t2_drained", exp_q.size(), 32'd0);

    // Wrap the FIFO pointers with credits returned every cycle.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 16'(i + 1), (i >= 4));
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, (m_cred < 4));
    check_val("t3_drained", exp_q.size(), 32'd0);
    check_val("t3_no_ovf", overflow_err, 32'd0);

    // Send and credit in the same cycle; then credit at the ceiling.
    do_reset();
    step(1'b1, 16'hA001, 1'b0);
    step(1'b1, 16'hA002, 1'b0);
    step(1'b1, 16'hA003, 1'b0);
    check_val("t4_pre_cred", credits, 32'd2);
    step(1'b0, 16'h0000, 1'b1);
    check_val("t4_same_cred", credits, 32'd2);
    check_val("t4_same_lv", link_valid, 32'd1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    check_val("t4_full_cred", credits, 32'd4);
    check_val("t4_cerr_clear", credit_err, 32'd0);
    step(1'b0, 16'h0000, 1'b1);
    check_val("t4_sat_cred", credits, 32'd4);
    check_val("t4_cerr", credit_err, 32'd1);

    // Reset with packets queued and a credit available: nothing may leak out.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    check_val("t5_occ3", occupancy, 32'd3);
    check_val("t5_cred1", credits, 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b0);

    // Idle input with a toggling data bus.
    for (int i = 0; i < 8; i++) step(1'b0, 16'($urandom_range(0, 65535)), 1'b0);
    check_val("t6_occ", occupancy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
